// File: rtl/arith_pkg.sv
// arith_pkg: shared types and constants for arith_exec_unit.
package arith_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int ITER_COUNT = 32;
    localparam logic [DATA_WIDTH-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} opcode_e;
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;
endpackage

// File: rtl/arith_if.sv
// arith_if: command/result bundle between the register file (master) and arith_exec_unit (slave).
interface arith_if;
    import arith_pkg::*;
    logic                  start;
    opcode_e               opcode;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [DATA_WIDTH-1:0] result_lo;
    logic [DATA_WIDTH-1:0] result_hi;
    modport master (output start, opcode, op_a, op_b, input busy, done, err, result_lo, result_hi);
    modport slave (input start, opcode, op_a, op_b, output busy, done, err, result_lo, result_hi);
endinterface

// File: rtl/arith_iter_div.sv
// arith_iter_div: restoring divider, one quotient bit per step, MSB first.
module arith_iter_div
    import arith_pkg::*;
(
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESETN,
    input  logic                  load,
    input  logic                  step,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder
);
    logic [DATA_WIDTH-1:0] dsr;
    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH:0]   diff;
    logic                  ge;

    always_comb begin
        shifted = {remainder, quotient[DATA_WIDTH-1]};
        diff    = shifted - {1'b0, dsr};
        ge      = shifted >= {1'b0, dsr};
    end

    // Dividend bits shift out of the quotient register's top as quotient bits shift in.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            quotient  <= '0;
            remainder <= '0;
            dsr       <= '0;
        end else if (load) begin
            quotient  <= dividend;
            remainder <= '0;
            dsr       <= divisor;
        end else if (step) begin
            remainder <= ge ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
            quotient  <= {quotient[DATA_WIDTH-2:0], ge};
        end
    end
endmodule

// File: rtl/arith_exec_unit.sv
// arith_exec_unit: ADD/SUB in one cycle, MUL/DIV iterated over 32 cycles.
// ARITH_DIV_EN compiles in the divider; without it opcode 3 returns err with zero results.
module arith_exec_unit
    import arith_pkg::*;
(
    input logic    S_AXI_ACLK,
    input logic    S_AXI_ARESETN,
    arith_if.slave bus
);
    state_e                state, state_nxt;
    opcode_e               opc_q;
    logic [DATA_WIDTH-1:0] a_q, res_lo, res_hi, ld_lo, ld_hi, div_lo, div_hi;
    logic [DATA_WIDTH:0]   sum, diff, mul_sum;
    logic [4:0]            cnt;
    logic                  err_q, accept, iter_op, last, div_err, ld_err;

    always_comb begin
        accept  = state == S_IDLE && bus.start;
        last    = cnt == 5'(ITER_COUNT - 1);
        sum     = {1'b0, bus.op_a} + {1'b0, bus.op_b};
        diff    = {1'b0, bus.op_a} - {1'b0, bus.op_b};
        mul_sum = {1'b0, res_hi} + (res_lo[0] ? {1'b0, a_q} : '0);
`ifdef ARITH_DIV_EN
        div_err = bus.op_b == '0;
        div_lo  = DIV0_QUOTIENT;
        div_hi  = bus.op_a;
`else
        div_err = 1'b1;
        div_lo  = '0;
        div_hi  = '0;
`endif
        iter_op = bus.opcode == OP_MUL || (bus.opcode == OP_DIV && !div_err);
        ld_lo   = bus.opcode == OP_ADD ? sum[DATA_WIDTH-1:0] :
                  bus.opcode == OP_SUB ? diff[DATA_WIDTH-1:0] :
                  bus.opcode == OP_MUL ? bus.op_b : div_lo;
        ld_hi   = bus.opcode == OP_ADD ? {{(DATA_WIDTH-1){1'b0}}, sum[DATA_WIDTH]} :
                  bus.opcode == OP_SUB ? {{(DATA_WIDTH-1){1'b0}}, diff[DATA_WIDTH]} :
                  bus.opcode == OP_DIV ? div_hi : '0;
        ld_err  = bus.opcode == OP_DIV && div_err;
    end

    always_ff @(posedge S_AXI_ACLK) begin
        state <= !S_AXI_ARESETN ? S_IDLE : state_nxt;
    end

    always_comb begin
        state_nxt = state;
        state_nxt = state == S_IDLE ? (accept ? (iter_op ? S_CALC : S_DONE) : S_IDLE) :
                    state == S_CALC ? (last ? S_DONE : S_CALC) : S_IDLE;
    end

    // MUL accumulates in place: {res_hi, res_lo} starts as {0, b} and shifts right each step.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            opc_q  <= OP_ADD;
            a_q    <= '0;
            res_lo <= '0;
            res_hi <= '0;
            err_q  <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            opc_q  <= bus.opcode;
            a_q    <= bus.op_a;
            res_lo <= ld_lo;
            res_hi <= ld_hi;
            err_q  <= ld_err;
            cnt    <= '0;
        end else if (state == S_CALC) begin
            cnt <= cnt + 5'd1;
            if (opc_q == OP_MUL) begin
                res_hi <= mul_sum[DATA_WIDTH:1];
                res_lo <= {mul_sum[0], res_lo[DATA_WIDTH-1:1]};
            end
        end
    end

    assign bus.busy = state != S_IDLE;
    assign bus.done = state == S_DONE;
    assign bus.err  = err_q;

`ifdef ARITH_DIV_EN
    logic                  div_sel;
    logic [DATA_WIDTH-1:0] quotient, remainder;

    arith_iter_div u_div (
        .S_AXI_ACLK   (S_AXI_ACLK),
        .S_AXI_ARESETN(S_AXI_ARESETN),
        .load         (accept && bus.opcode == OP_DIV),
        .step         (state == S_CALC && opc_q == OP_DIV),
        .dividend     (bus.op_a),
        .divisor      (bus.op_b),
        .quotient     (quotient),
        .remainder    (remainder)
    );

    // Iterative DIV results live in the divider, which holds them until the next load.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN)
            div_sel <= 1'b0;
        else if (accept)
            div_sel <= bus.opcode == OP_DIV && !div_err;
    end

    assign bus.result_lo = div_sel ? quotient : res_lo;
    assign bus.result_hi = div_sel ? remainder : res_hi;
`else
    assign bus.result_lo = res_lo;
    assign bus.result_hi = res_hi;
`endif
endmodule

// File: tb/tb_arith_exec_unit.sv
// tb_arith_exec_unit: randomized scoreboard bench against a plain-arithmetic reference model.
module tb_arith_exec_unit;
    import arith_pkg::*;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        err;
        int          lat;
        int          t;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    arith_if bus ();

    arith_exec_unit dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(rstn),
        .bus          (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, longint unsigned act, longint unsigned req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic exp_t model(logic [1:0] op, logic [31:0] a, logic [31:0] b);
        exp_t        e;
        logic [63:0] w;
        e.err = 1'b0;
        e.lat = 1;
        e.t   = 0;
        e.lo  = '0;
        e.hi  = '0;
        case (op)
            2'd0: begin
                w    = 64'(a) + 64'(b);
                e.lo = w[31:0];
                e.hi = w[63:32];
            end
            2'd1: begin
                e.lo = a - b;
                e.hi = (a < b) ? 32'd1 : 32'd0;
            end
            2'd2: begin
                w     = 64'(a) * 64'(b);
                e.lo  = w[31:0];
                e.hi  = w[63:32];
                e.lat = 33;
            end
            default: begin
`ifdef ARITH_DIV_EN
                if (b == 0) begin
                    e.lo  = 32'hFFFF_FFFF;
                    e.hi  = a;
                    e.err = 1'b1;
                end else begin
                    e.lo  = a / b;
                    e.hi  = a % b;
                    e.lat = 33;
                end
`else
                e.err = 1'b1;
`endif
            end
        endcase
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rstn && bus.done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("result_lo", bus.result_lo, e.lo);
                chk("result_hi", bus.result_hi, e.hi);
                chk("err", bus.err, e.err);
                chk("latency", longint'(cyc - e.t + 1), longint'(e.lat));
                chk("busy_in_done", bus.busy, 1);
            end
        end
    end

    task automatic issue(logic [1:0] op, logic [31:0] a, logic [31:0] b, bit push);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        while (bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("idle_timeout", 1, 0);
        bus.start  = 1'b1;
        bus.opcode = opcode_e'(op);
        bus.op_a   = a;
        bus.op_b   = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (push) begin
            e   = model(op, a, b);
            e.t = cyc;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_outstanding", exp_q.size(), 0);
    endtask

    task automatic check_idle_zero(string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_err"}, bus.err, 0);
        chk({tag, "_lo"}, bus.result_lo, 0);
        chk({tag, "_hi"}, bus.result_hi, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a, b;
        bus.start  = 1'b0;
        bus.opcode = OP_ADD;
        bus.op_a   = '0;
        bus.op_b   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_zero("reset");
        rstn = 1'b1;

        issue(2'd0, 32'hFFFF_FFFF, 32'd1, 1);
        @(negedge clk);
        @(negedge clk);
        chk("add_busy_after_done", bus.busy, 0);
        issue(2'd1, 32'd5, 32'd7, 1);

        issue(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        repeat (9) @(negedge clk);
        bus.start  = 1'b1;
        bus.opcode = OP_ADD;
        bus.op_a   = 32'd2;
        bus.op_b   = 32'd2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        drain();

        issue(2'd3, 32'd100, 32'd7, 1);
        issue(2'd3, 32'd42, 32'd0, 1);
        drain();

        issue(2'd2, 32'h1234_5678, 32'h9ABC_DEF0, 0);
        repeat (14) @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle_zero("midcalc_reset");
        rstn = 1'b1;
        issue(2'd0, 32'd3, 32'd4, 1);
        drain();

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: a = 32'hFFFF_FFFF;
                1: a = $urandom_range(0, 20);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            issue(2'($urandom_range(0, 3)), a, b, 1);
        end
        drain();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/arith_exec_unit.md
# arith_exec_unit

Execution stage directly downstream of the arithmetic AXI4-Lite slave register file. It takes two 32-bit unsigned operands, a 2-bit opcode and a start pulse decoded from the slave registers, and computes the selected operation. ADD and SUB complete in a single cycle; MUL and DIV are iterative, one bit per cycle. The result pair and status flags are returned to the register file as read-only values for the AXI master to poll.

## Interface
- DATA_WIDTH, 32, operand/result word width; fixed at 32 in this release
- S_AXI_ACLK  in  1  sole clock, rising edge
- S_AXI_ARESETN  in  1  reset; synchronous, active-low
- start  in  1  one-cycle request pulse; accepted only in IDLE
- opcode  in  2  0=ADD, 1=SUB, 2=MUL, 3=DIV; sampled with start
- op_a  in  32  operand A / dividend; sampled with start
- op_b  in  32  operand B / divisor; sampled with start
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse when the result is valid
- err  out  1  divide-by-zero or disabled op; held with the result
- result_lo  out  32  sum / difference / product[31:0] / quotient
- result_hi  out  32  carry / borrow in bit 0 / product[63:32] / remainder

## Operation
- States: IDLE, CALC, DONE.
- IDLE with start=1:
  - latch opcode, op_a and op_b; clear err
  - ADD, SUB, DIV-by-zero and disabled DIV go directly to DONE
  - MUL and valid DIV go to CALC with iteration count = 0
- Start while busy is ignored; latched operands are not disturbed.
- ADD: result_lo = (a+b)[31:0]; result_hi = {31'b0, carry-out}.
- SUB: result_lo = (a-b)[31:0]; result_hi = {31'b0, borrow}, where borrow = (a<b).
- MUL: unsigned shift-add over a 64-bit accumulator, one multiplier bit per CALC cycle, LSB first. Produces a full 64-bit product with no truncation.
- DIV: unsigned restoring division, one quotient bit per CALC cycle, MSB first.
  - result_lo = quotient, result_hi = remainder
  - b=0: result_lo = 32'hFFFF_FFFF, result_hi = a, err = 1
- CALC exits to DONE after exactly 32 iterations (count 0..31).
- DONE: done=1 for one cycle, then IDLE.
- result_lo, result_hi and err hold their values until the next accepted start.
- Reset (ARESETN=0 at any clock edge, including mid-CALC):
  - state = IDLE; busy, done, err = 0; result_lo, result_hi = 0; count = 0
  - any operation in flight is discarded

## Timing
- Cycle numbering: start is sampled high in IDLE at edge T.
- ADD, SUB, DIV-by-zero, disabled DIV: state = DONE after edge T; done is high during cycle T+1.
  - Latency 1.
- MUL, DIV: state = CALC from edge T through T+32, DONE after edge T+32; done is high during cycle T+33.
  - Latency 33.
- busy is high from the cycle after T through the DONE cycle inclusive.
- Results are valid in the same cycle done is asserted.
- Back-to-back: a start presented in the DONE cycle is ignored. The earliest accepted start is the first IDLE cycle, so the minimum issue interval is 2 cycles for single-cycle ops.
- Register-file contract: start is a one-cycle pulse generated on the AXI write to the control register. A pulse that lands while busy is lost, and the master polls busy before writing the next command.

## Configuration
- ARITH_DIV_EN defined: restoring divider is compiled in; opcode 3 behaves as described above.
- ARITH_DIV_EN undefined: no divider logic is compiled in. Opcode 3 completes in 1 cycle with result_lo = 0, result_hi = 0, err = 1.
- ADD, SUB and MUL are unaffected by the macro in both builds.

## Structure
- Package arith_pkg holds:
  - opcode enum (OP_ADD, OP_SUB, OP_MUL, OP_DIV)
  - state enum (S_IDLE, S_CALC, S_DONE)
  - ITER_COUNT = 32
  - DIV0_QUOTIENT = 32'hFFFF_FFFF
- One sub-module, arith_iter_div: restoring-divide datapath (remainder and quotient shift registers plus subtractor).
  - Stepped by the parent FSM via load and step enables.
  - Instantiated only under ARITH_DIV_EN.
- The MUL datapath and ADD/SUB logic stay in the parent.

## Test plan
- ADD a=32'hFFFF_FFFF, b=1 -> done at T+1; result_lo=0, result_hi=1, err=0, busy high during T+1 only.
- SUB a=5, b=7 -> result_lo=32'hFFFF_FFFE, result_hi=1, latency 1.
- MUL a=32'hFFFF_FFFF, b=32'hFFFF_FFFF -> done at T+33; result_hi=32'hFFFF_FFFE, result_lo=1. A second start at T+10 with a=2, b=2 is ignored and the result is unchanged.
- DIV a=100, b=7 (ARITH_DIV_EN) -> done at T+33; result_lo=14, result_hi=2, err=0.
- DIV a=42, b=0 -> done at T+1; result_lo=32'hFFFF_FFFF, result_hi=42, err=1. In a build without ARITH_DIV_EN, any DIV -> done at T+1, results 0, err=1.
- Reset asserted at T+15 of a MUL -> after that edge busy=0, done=0, results=0, state IDLE. A new ADD 3+4 started afterwards -> result_lo=7 at latency 1.
